// File: rtl/norm2_mul_arb_pkg.sv
// Shared types and widths for the norm2 shared-multiplier arbiter.
package norm2_mul_arb_pkg;

  localparam int OPERAND_W = 18;
  localparam int PRODUCT_W = 36;
  localparam int REQ_ID_W  = 2;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;
  typedef logic [REQ_ID_W-1:0]  req_id_t;

endpackage

// File: rtl/norm2_mul_18ns_18ns_36_1_0.sv
// 18x18 unsigned combinational multiplier with an exact 36-bit product.
module norm2_mul_18ns_18ns_36_1_0
  import norm2_mul_arb_pkg::*;
(
  input  operand_t din0,
  input  operand_t din1,
  output product_t dout
);

  // Both operands are zero-extended to the full product width, so nothing is truncated.
  assign dout = {{(PRODUCT_W-OPERAND_W){1'b0}}, din0} * {{(PRODUCT_W-OPERAND_W){1'b0}}, din1};

endmodule

// File: rtl/norm2_rr_arbiter.sv
// Rotating-priority grant: the first active request at or after rr_ptr wins.
module norm2_rr_arbiter
  import norm2_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  int best_off;
  int off;

  // Pick the requester with the smallest circular distance from rr_ptr.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_vld    = 1'b0;
    best_off     = NUM_REQ;
    off          = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = i - int'(rr_ptr);
      if (off < 0) off = off + NUM_REQ;
      if (enable && req[i] && (off < best_off)) begin
        best_off        = off;
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
        grant_idx       = ID_W'(i);
        grant_vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm2_mul_arbiter.sv
// Shares one 18x18 multiplier among NUM_REQ requesters through a two-stage
// pipeline (operand register, product register) with round-robin grant.
module norm2_mul_arbiter
  import norm2_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [PRODUCT_W-1:0]           rsp_data,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           busy,
  output logic [CNT_W-1:0]               done_cnt
);

  // Operand stage
  logic            s1_valid_q, s1_valid_d;
  operand_t        s1_a_q, s1_a_d;
  operand_t        s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  // Product stage
  logic            s2_valid_q, s2_valid_d;
  product_t        s2_data_q, s2_data_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  // Control
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic               adv1, adv2, arb_en;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  operand_t           sel_a, sel_b;
  product_t           mul_dout;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    else                        return g + ID_W'(1);
  endfunction

  // Stage advance conditions; a stalled product stage back-propagates to the grant.
  always_comb begin
    adv2   = !s2_valid_q || rsp_ready;
    adv1   = !s1_valid_q || adv2;
    arb_en = adv1 && !ap_rst;
  end

  norm2_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req          (req_valid),
    .rr_ptr       (rr_ptr_q),
    .enable       (arb_en),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_vld    (grant_vld)
  );

  assign req_ready = grant_onehot;

  // One-hot operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a = req_a[i*OPERAND_W +: OPERAND_W];
        sel_b = req_b[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  norm2_mul_18ns_18ns_36_1_0 u_mul (
    .din0 (s1_a_q),
    .din1 (s1_b_q),
    .dout (mul_dout)
  );

  // Next-state for both pipeline stages, the grant pointer and the completion counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    done_cnt_d = done_cnt_q;

    if (grant_vld) begin
      s1_valid_d = 1'b1;
      s1_a_d     = sel_a;
      s1_b_d     = sel_b;
      s1_id_d    = grant_idx;
      rr_ptr_d   = ptr_after(grant_idx);
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    // Product data only moves with a real operand, so an idle cycle never disturbs rsp_data.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = mul_dout;
        s2_id_d   = s1_id_q;
      end
    end

    if (s2_valid_q && rsp_ready) done_cnt_d = done_cnt_q + CNT_W'(1);
  end

  // Control and response registers; reset drops any in-flight work immediately.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Operand registers carry data only; their contents are qualified by s1_valid_q.
  always_ff @(posedge ap_clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_id_q <= s1_id_d;
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_norm2_mul_arbiter.sv
// Directed bench for norm2_mul_arbiter with hand-computed expectations.
module tb_norm2_mul_arbiter;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [71:0] req_a;
  logic [71:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [35:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [31:0] done_cnt;

  int tests_run;
  int tests_failed;
  int exp_done;

  norm2_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(32)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic set_ops(input int idx, input logic [17:0] a, input logic [17:0] b);
    req_a[idx*18 +: 18] = a;
    req_b[idx*18 +: 18] = b;
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
    #12;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (done_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
    tests_run++; if (rsp_data !== 36'd0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    req_valid = 4'h0;
    @(negedge ap_clk); ap_rst = 1'b0;
    exp_done = 0;
  endtask

  task automatic pulse_reset;
    @(negedge ap_clk); ap_rst = 1'b1;
    @(negedge ap_clk); ap_rst = 1'b0;
    exp_done = 0;
  endtask

  task automatic test_single;
    @(negedge ap_clk);
    rsp_ready = 1'b1; set_ops(0, 18'd3, 18'd5); req_valid = 4'b0001;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0000;
    #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %0b want 1", busy); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_vld: got %0b want 0", rsp_valid); end
    @(posedge ap_clk); #1;
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_vld: got %0b want 1", rsp_valid); end
    tests_run++; if (rsp_data !== 36'd15) begin tests_failed++; $display("FAIL single_data: got %0d want 15", rsp_data); end
    tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    tests_run++; if (done_cnt !== 32'd0) begin tests_failed++; $display("FAIL single_cnt_before: got %0d want 0", done_cnt); end
    @(posedge ap_clk); #1;
    exp_done = 1;
    tests_run++; if (done_cnt !== 32'd1) begin tests_failed++; $display("FAIL single_cnt_after: got %0d want 1", done_cnt); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_vld_after: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_max_operands;
    @(negedge ap_clk);
    set_ops(2, 18'h3FFFF, 18'h3FFFF); req_valid = 4'b0100;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL max_ready: got %b want 0100", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0000;
    @(posedge ap_clk); #1;
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL max_vld: got %0b want 1", rsp_valid); end
    tests_run++; if (rsp_data !== 36'hFFFF80001) begin tests_failed++; $display("FAIL max_data: got %h want FFFF80001", rsp_data); end
    tests_run++; if (rsp_id !== 2'd2) begin tests_failed++; $display("FAIL max_id: got %0d want 2", rsp_id); end
    @(posedge ap_clk); #1;
    exp_done++;
    tests_run++; if (done_cnt !== 32'(exp_done)) begin tests_failed++; $display("FAIL max_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_round_robin;
    logic [3:0]  want_ready;
    logic [1:0]  want_id;
    logic [35:0] want_data;
    @(negedge ap_clk);
    for (int i = 0; i < 4; i++) set_ops(i, 18'(i + 1), 18'd10);
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 11; c++) begin
      if (c == 8) req_valid = 4'h0;
      #1;
      want_ready = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      tests_run++; if (req_ready !== want_ready) begin tests_failed++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, want_ready); end
      if (c >= 2 && c <= 9) begin
        want_id   = 2'((c - 2) % 4);
        want_data = 36'((((c - 2) % 4) + 1) * 10);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rr_vld[%0d]: got %0b want 1", c, rsp_valid); end
        tests_run++; if (rsp_id !== want_id) begin tests_failed++; $display("FAIL rr_id[%0d]: got %0d want %0d", c, rsp_id, want_id); end
        tests_run++; if (rsp_data !== want_data) begin tests_failed++; $display("FAIL rr_data[%0d]: got %0d want %0d", c, rsp_data, want_data); end
      end else begin
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_idle_vld[%0d]: got %0b want 0", c, rsp_valid); end
      end
      @(posedge ap_clk); #1;
    end
    exp_done += 8;
    tests_run++; if (done_cnt !== 32'(exp_done)) begin tests_failed++; $display("FAIL rr_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_backpressure;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    set_ops(0, 18'd7, 18'd11); set_ops(1, 18'd100, 18'd200); set_ops(2, 18'd9, 18'd9);
    req_valid = 4'b0011;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_ready0: got %b want 0001", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0010; #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_ready1: got %b want 0010", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0100; #1;
    for (int c = 0; c < 5; c++) begin
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, req_ready); end
      tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_stall_vld[%0d]: got %0b want 1", c, rsp_valid); end
      tests_run++; if (rsp_data !== 36'd77) begin tests_failed++; $display("FAIL bp_stall_data[%0d]: got %0d want 77", c, rsp_data); end
      tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL bp_stall_id[%0d]: got %0d want 0", c, rsp_id); end
      @(posedge ap_clk); #2;
    end
    rsp_ready = 1'b1; #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL bp_resume_ready: got %b want 0100", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0000; #1;
    tests_run++; if (rsp_data !== 36'd20000) begin tests_failed++; $display("FAIL bp_data1: got %0d want 20000", rsp_data); end
    tests_run++; if (rsp_id !== 2'd1) begin tests_failed++; $display("FAIL bp_id1: got %0d want 1", rsp_id); end
    @(posedge ap_clk); #1;
    tests_run++; if (rsp_data !== 36'd81) begin tests_failed++; $display("FAIL bp_data2: got %0d want 81", rsp_data); end
    tests_run++; if (rsp_id !== 2'd2) begin tests_failed++; $display("FAIL bp_id2: got %0d want 2", rsp_id); end
    @(posedge ap_clk); #1;
    exp_done += 3;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_vld: got %0b want 0", rsp_valid); end
    tests_run++; if (done_cnt !== 32'(exp_done)) begin tests_failed++; $display("FAIL bp_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_skip_idle;
    logic [3:0] want_ready;
    logic [1:0] want_id;
    // Move the pointer to 2 with a lone request from requester 1.
    @(negedge ap_clk);
    set_ops(1, 18'd2, 18'd2); set_ops(3, 18'd6, 18'd7);
    req_valid = 4'b0010; #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL skip_prep_ready: got %b want 0010", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'b0000;
    @(posedge ap_clk); #1;
    tests_run++; if (rsp_data !== 36'd4) begin tests_failed++; $display("FAIL skip_prep_data: got %0d want 4", rsp_data); end
    @(posedge ap_clk); #1;
    exp_done++;
    req_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) req_valid = 4'b0000;
      #1;
      want_ready = (c >= 3) ? 4'b0000 : ((c % 2 == 0) ? 4'b1000 : 4'b0010);
      tests_run++; if (req_ready !== want_ready) begin tests_failed++; $display("FAIL skip_ready[%0d]: got %b want %b", c, req_ready, want_ready); end
      if (c >= 2 && c <= 4) begin
        want_id = (c == 3) ? 2'd1 : 2'd3;
        tests_run++; if (rsp_id !== want_id) begin tests_failed++; $display("FAIL skip_id[%0d]: got %0d want %0d", c, rsp_id, want_id); end
        tests_run++; if (rsp_data !== ((c == 3) ? 36'd4 : 36'd42)) begin tests_failed++; $display("FAIL skip_data[%0d]: got %0d", c, rsp_data); end
      end
      @(posedge ap_clk); #1;
    end
    exp_done += 3;
    tests_run++; if (done_cnt !== 32'(exp_done)) begin tests_failed++; $display("FAIL skip_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_async_reset;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    set_ops(0, 18'd1, 18'd1); set_ops(1, 18'd1, 18'd1);
    req_valid = 4'b0011;
    @(posedge ap_clk); #1; req_valid = 4'b0010;
    @(posedge ap_clk); #1; req_valid = 4'b0000; #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ar_pre_busy: got %0b want 1", busy); end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL ar_pre_vld: got %0b want 1", rsp_valid); end
    #1; ap_rst = 1'b1; #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ar_vld: got %0b want 0", rsp_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ar_busy: got %0b want 0", busy); end
    tests_run++; if (done_cnt !== 32'd0) begin tests_failed++; $display("FAIL ar_cnt: got %0d want 0", done_cnt); end
    req_valid = 4'hF; #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL ar_ready: got %b want 0000", req_ready); end
    @(posedge ap_clk); #1;
    @(negedge ap_clk); ap_rst = 1'b0; req_valid = 4'h0; rsp_ready = 1'b1;
    exp_done = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge ap_clk); #1;
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ar_stale_vld[%0d]: got %0b want 0", c, rsp_valid); end
    end
    set_ops(0, 18'd4, 18'd4); req_valid = 4'hF; #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL ar_first_grant: got %b want 0001", req_ready); end
    @(posedge ap_clk); #1; req_valid = 4'h0;
    @(posedge ap_clk); #1;
    tests_run++; if (rsp_id !== 2'd0) begin tests_failed++; $display("FAIL ar_new_id: got %0d want 0", rsp_id); end
    tests_run++; if (rsp_data !== 36'd16) begin tests_failed++; $display("FAIL ar_new_data: got %0d want 16", rsp_data); end
    @(posedge ap_clk); #1;
    tests_run++; if (done_cnt !== 32'd1) begin tests_failed++; $display("FAIL ar_new_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; exp_done = 0;
    ap_rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_max_operands();
    pulse_reset();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
